// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, fixed latency.
// Define DIV_SIGNED_EN for two's-complement operands (truncating quotient).
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Dividend_in,
    input  logic [WIDTH-1:0] Divisor_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] Quotient_out,
    output logic [WIDTH-1:0] Remainder_out,
    output logic [1:0]       o_dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fit;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_res;
    logic [WIDTH-1:0] w_rem_res;

`ifdef DIV_SIGNED_EN
    logic r_q_neg;
    logic r_r_neg;
    // Divide magnitudes, then restore signs; most-negative/-1 wraps back to itself.
    assign w_dvd_mag = Dividend_in[WIDTH-1] ? -Dividend_in : Dividend_in;
    assign w_dvs_mag = Divisor_in[WIDTH-1]  ? -Divisor_in  : Divisor_in;
    assign w_quo_res = r_q_neg ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_res = r_r_neg ? -w_rem_nxt : w_rem_nxt;
`else
    assign w_dvd_mag = Dividend_in;
    assign w_dvs_mag = Divisor_in;
    assign w_quo_res = w_quo_nxt;
    assign w_rem_res = w_rem_nxt;
`endif

    // The partial remainder is always below the divisor, so a borrow out of bit WIDTH means no fit.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_fit     = ~w_diff[WIDTH];
    assign w_rem_nxt = w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fit};

    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_quo         <= '0;
            r_rem         <= '0;
            r_dvs         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            div_by_zero   <= 1'b0;
            Quotient_out  <= '0;
            Remainder_out <= '0;
`ifdef DIV_SIGNED_EN
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        div_by_zero <= 1'b0;
                        r_quo       <= w_dvd_mag;
                        r_rem       <= '0;
                        r_dvs       <= w_dvs_mag;
                        r_cnt       <= CW'(WIDTH);
`ifdef DIV_SIGNED_EN
                        r_q_neg     <= Dividend_in[WIDTH-1] ^ Divisor_in[WIDTH-1];
                        r_r_neg     <= Dividend_in[WIDTH-1];
`endif
                        if (Divisor_in == '0) begin
                            r_state       <= DONE;
                            done          <= 1'b1;
                            div_by_zero   <= 1'b1;
                            Quotient_out  <= '1;
                            Remainder_out <= Dividend_in;
                        end else begin
                            r_state <= CALC;
                            busy    <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state       <= DONE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        Quotient_out  <= w_quo_res;
                        Remainder_out <= w_rem_res;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a 32-bit and an 8-bit instance, hand-computed results.
// Handshake: start is sampled only in IDLE; done is a one-cycle pulse with results valid.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic        start32, start8;
    logic [31:0] a32, b32, q32, r32;
    logic [7:0]  a8, b8, q8, r8;
    logic        busy32, done32, dz32, busy8, done8, dz8;
    logic [1:0]  st32, st8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .Reset(rst), .start(start32), .Dividend_in(a32), .Divisor_in(b32),
        .busy(busy32), .done(done32), .div_by_zero(dz32),
        .Quotient_out(q32), .Remainder_out(r32), .o_dbg_state(st32)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .Reset(rst), .start(start8), .Dividend_in(a8), .Divisor_in(b8),
        .busy(busy8), .done(done8), .div_by_zero(dz8),
        .Quotient_out(q8), .Remainder_out(r8), .o_dbg_state(st8)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns edges counted from the accepting edge (that edge is 1) until done is seen.
    task automatic do_div(input bit w8, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit busy_seen);
        @(negedge clk);
        if (w8) begin start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; end
        else    begin start32 = 1'b1; a32 = a; b32 = b; end
        @(posedge clk); #1;
        start8 = 1'b0; start32 = 1'b0;
        busy_seen = w8 ? busy8 : busy32;
        lat = 1;
        while (!(w8 ? done8 : done32) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic div32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input bit edz);
        int lat; bit bs;
        do_div(1'b0, a, b, lat, bs);
        check_eq({tag, "_lat"}, 64'(lat), edz ? 64'd1 : 64'd33);
        check_eq({tag, "_busy"}, 64'(bs), edz ? 64'd0 : 64'd1);
        check_eq({tag, "_q"}, 64'(q32), 64'(eq));
        check_eq({tag, "_r"}, 64'(r32), 64'(er));
        check_eq({tag, "_dz"}, 64'(dz32), 64'(edz));
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, 64'(done32), 64'd0);
    endtask

    task automatic div8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er);
        int lat; bit bs;
        do_div(1'b1, 32'(a), 32'(b), lat, bs);
        check_eq({tag, "_lat"}, 64'(lat), 64'd9);
        check_eq({tag, "_q"}, 64'(q8), 64'(eq));
        check_eq({tag, "_r"}, 64'(r8), 64'(er));
        @(posedge clk); #1;
    endtask

    initial begin
        int n_done;
        int first_done;
        rst = 1'b1; start32 = 1'b0; start8 = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy32), 64'd0);
        check_eq("rst_done", 64'(done32), 64'd0);
        check_eq("rst_dz", 64'(dz32), 64'd0);
        check_eq("rst_q", 64'(q32), 64'd0);
        check_eq("rst_r", 64'(r32), 64'd0);
        check_eq("rst_state", 64'(st32), 64'd0);
        @(negedge clk); rst = 1'b0;

        div32("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("hold_q", 64'(q32), 64'd14);
        check_eq("hold_r", 64'(r32), 64'd2);

        div32("d1234_0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
        check_eq("dz_held", 64'(dz32), 64'd1);
        div32("d100_7b", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        // Second start during CALC, with operands changed afterwards, must be ignored.
        @(negedge clk); start32 = 1'b1; a32 = 32'd100; b32 = 32'd7;
        @(posedge clk); #1; start32 = 1'b0;
        n_done = 0; first_done = 0;
        for (int e = 2; e <= 45; e++) begin
            if (e == 11) begin
                @(negedge clk); start32 = 1'b1; a32 = 32'd50; b32 = 32'd5;
            end else if (e == 12) begin
                @(negedge clk); start32 = 1'b0;
            end
            @(posedge clk); #1;
            if (done32) begin
                n_done++;
                if (first_done == 0) first_done = e;
            end
            if (e == 33) begin
                check_eq("ign_q", 64'(q32), 64'd14);
                check_eq("ign_r", 64'(r32), 64'd2);
            end
        end
        check_eq("ign_ndone", 64'(n_done), 64'd1);
        check_eq("ign_edge", 64'(first_done), 64'd33);

        // Reset in the middle of a division.
        @(negedge clk); start32 = 1'b1; a32 = 32'd100; b32 = 32'd7;
        @(posedge clk); #1; start32 = 1'b0;
        repeat (13) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_busy", 64'(busy32), 64'd0);
        check_eq("abort_done", 64'(done32), 64'd0);
        check_eq("abort_q", 64'(q32), 64'd0);
        check_eq("abort_r", 64'(r32), 64'd0);
        check_eq("abort_state", 64'(st32), 64'd0);
        @(negedge clk); rst = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32) n_done++;
        end
        check_eq("abort_nodone", 64'(n_done), 64'd0);
        div32("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        div8("w8_255_1", 8'd255, 8'd1, 8'd255, 8'd0);
        div8("w8_5_200", 8'd5, 8'd200, 8'd0, 8'd5);

`ifdef DIV_SIGNED_EN
        div32("s_m7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        div32("s_7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        div8("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00);
`else
        div32("u_big_2", 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
        div32("u_7_big", 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd7, 1'b0);
        div8("u_128_255", 8'h80, 8'hFF, 8'h00, 8'h80);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, quotient and remainder width (legal range 4..64).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a division, sampled in IDLE only.
REQ-005 The block SHALL have port Dividend_in, input, WIDTH bits, the dividend, captured on the edge that accepts start.
REQ-006 The block SHALL have port Divisor_in, input, WIDTH bits, the divisor, captured on the edge that accepts start.
REQ-007 The block SHALL have port busy, output, 1 bit, high while a division is in progress (CALC state).
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking valid results.
REQ-009 The block SHALL have port div_by_zero, output, 1 bit, high with done when the captured divisor was 0; held until the next accepted start.
REQ-010 The block SHALL have port Quotient_out, output, WIDTH bits, the result quotient.
REQ-011 The block SHALL have port Remainder_out, output, WIDTH bits, the result remainder.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE.
REQ-013 IDLE with start=1 SHALL capture both operands, clear div_by_zero, load a counter with WIDTH and go to CALC; if the divisor is 0, it SHALL instead go straight to DONE.
REQ-014 CALC SHALL perform one restoring shift-subtract iteration per cycle and decrement the counter; at count 0 it SHALL go to DONE.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-016 Latency from the start-accepting edge SHALL be: done high after WIDTH+1 edges for a nonzero divisor; after 1 edge for a zero divisor.
REQ-017 Quotient_out and Remainder_out SHALL update only on entry to DONE and then hold until the next DONE.
REQ-018 start SHALL be ignored in CALC and DONE (no re-capture, no restart); the minimum start-to-start period SHALL be WIDTH+2 cycles.
REQ-019 Divide by zero SHALL give Quotient_out = all ones, Remainder_out = captured dividend and div_by_zero=1.
REQ-020 Results SHALL satisfy Dividend = Quotient*Divisor + Remainder with |Remainder| < |Divisor|, computed at WIDTH bits with no overflow.
REQ-021 Operand inputs changing after capture SHALL NOT affect the division in progress.

Reset
REQ-022 Reset=1 on a rising edge SHALL force IDLE and clear busy, done, div_by_zero, Quotient_out, Remainder_out, the counter and the internal registers to 0.
REQ-023 Reset SHALL take priority over start and abort any division in progress; no done pulse SHALL follow the abort.
REQ-024 After reset release, the first edge with start=1 SHALL be accepted.

Configuration
REQ-025 With macro DIV_SIGNED_EN defined, operands SHALL be two's complement.
REQ-026 Under DIV_SIGNED_EN, the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-027 Under DIV_SIGNED_EN, most-negative / -1 SHALL give Quotient_out = most-negative and Remainder_out = 0.
REQ-028 Under DIV_SIGNED_EN, the latency SHALL be unchanged.
REQ-029 Without DIV_SIGNED_EN, operands SHALL be unsigned and no sign-correction logic SHALL be present.

Verification
REQ-030 The bench SHALL cover: WIDTH=32, start with 100/7 -> done exactly 33 edges later, Q=14, R=2, div_by_zero=0.
REQ-031 The bench SHALL cover: start with 1234/0 -> done after 1 edge, Q=32'hFFFFFFFF, R=1234, div_by_zero=1.
REQ-032 The bench SHALL cover: start 100/7, pulse start with 50/5 at cycle 10 -> single done at edge 33 with Q=14, R=2; the second request is ignored.
REQ-033 The bench SHALL cover: Reset asserted at cycle 15 of a division -> next cycle IDLE with all outputs 0 and no done pulse; a new start 9/3 then gives Q=3, R=0.
REQ-034 The bench SHALL cover: WIDTH=8, 255/1 -> Q=255, R=0 after 9 edges; 5/200 -> Q=0, R=5.
REQ-035 The bench SHALL cover, with DIV_SIGNED_EN: -7/2 -> Q=-3, R=-1; 7/-2 -> Q=-3, R=1; WIDTH=8, -128/-1 -> Q=-128, R=0.
